// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU constants: funct3 encodings, FSM state encoding, address width
// default, and request decode helpers reused by the decode stage.
package lsu_ctrl_pkg;

    localparam int unsigned AW_DEFAULT = 6;
    localparam int unsigned XLEN       = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_REQ  = 3'd1,
        S_LD_DATA = 3'd2,
        S_ST_WR   = 3'd3,
        S_RMW_RD  = 3'd4,
        S_RMW_WR  = 3'd5,
        S_ERR     = 3'd6
    } lsu_state_e;

    // Stores only define B/H/W; loads additionally define BU/HU.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3[2] || (f3 == 3'b011);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b10:   return a != 2'b00;
            2'b01:   return a[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_lane.sv
// Byte/halfword lane extraction for loads and lane merge for sub-word stores.
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged_word
);

    localparam int unsigned BW = 8;
    localparam int unsigned HW = 16;

    logic [BW-1:0] ld_byte;
    logic [HW-1:0] ld_half;

    always_comb begin
        ld_byte = word[{addr, 3'b000} +: BW];
        ld_half = word[{addr[1], 4'b0000} +: HW];

        case (funct3)
            F3_B:    load_data = {{(XLEN-BW){ld_byte[BW-1]}}, ld_byte};
            F3_BU:   load_data = XLEN'(ld_byte);
            F3_H:    load_data = {{(XLEN-HW){ld_half[HW-1]}}, ld_half};
            F3_HU:   load_data = XLEN'(ld_half);
            default: load_data = word;
        endcase

        merged_word = word;
        case (funct3[1:0])
            2'b00:   merged_word[{addr, 3'b000} +: BW]    = wdata[BW-1:0];
            2'b01:   merged_word[{addr[1], 4'b0000} +: HW] = wdata[HW-1:0];
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single outstanding request to a word-wide
// synchronous memory, with read-modify-write for byte/halfword stores.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      state_q, state_d;
    logic [2:0]      f3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [AW-1:0]   mem_addr_q;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;
    logic            accept;
    logic            req_bad;
    logic            unused_addr_hi;

    assign accept         = req_valid && (state_q == S_IDLE);
    assign req_bad        = f3_illegal(req_is_store, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
    assign unused_addr_hi = ^req_addr[XLEN-1:AW+2];
    assign mem_addr       = mem_addr_q;

    lsu_lane u_lane (
        .word        (mem_rdata),
        .addr        (addr_lo_q),
        .funct3      (f3_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Memory address and write data only move when a real access is set up,
    // so they hold their last values through idle and error cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            f3_q        <= 3'b000;
            addr_lo_q   <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q      <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata;
                if (!req_bad) begin
                    mem_addr_q <= req_addr[AW+1:2];
                end
                if (!req_bad && req_is_store && (req_funct3 == F3_W)) begin
                    mem_wdata_q <= req_wdata;
                end
            end
            if (state_q == S_RMW_WR) begin
                mem_wdata_q <= merged_word;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)                  state_d = S_ERR;
                    else if (!req_is_store)       state_d = S_LD_REQ;
                    else if (req_funct3 == F3_W)  state_d = S_ST_WR;
                    else                          state_d = S_RMW_RD;
                end
            end
            S_LD_REQ: begin
                mem_req = 1'b1;
                state_d = S_LD_DATA;
            end
            S_LD_DATA: begin
                resp_valid = 1'b1;
                resp_rdata = load_data;
                state_d    = S_IDLE;
            end
            S_ST_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            S_RMW_RD: begin
                mem_req = 1'b1;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_wdata  = merged_word;
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have a parameter AW, default 6, giving the log2 of the memory depth in 32-bit words (64 words, 256 bytes).
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, with the ports below (clock and reset first).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  pipeline presents a memory request.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended as required by funct3; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned access or illegal funct3.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  1 = write the full word.
- mem_addr  out  AW  word index, taken from req_addr[AW+1:2].
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word, valid the cycle after a mem_req with mem_we=0.

Function
REQ-003 The block SHALL accept a request on a rising edge where req_valid and req_ready are both high, and SHALL register funct3, is_store, addr and wdata at that edge.
REQ-004 The FSM SHALL have the states IDLE, LD_REQ, LD_DATA, ST_WR, RMW_RD, RMW_WR and ERR.
REQ-005 On accept, the FSM SHALL move from IDLE as follows:
- Load with legal funct3 and aligned address: to LD_REQ.
- SW, aligned: to ST_WR.
- SB or SH, aligned: to RMW_RD.
- Any other case: to ERR.
REQ-006 Alignment SHALL be checked as follows:
- Word accesses are misaligned when addr[1:0] != 0.
- Halfword accesses are misaligned when addr[0] != 0.
- Byte accesses are never misaligned.
- Illegal funct3 values are loads 011, 110, 111 and stores 011 to 111.
REQ-007 In LD_REQ the block SHALL drive mem_req=1 and mem_we=0, then go to LD_DATA.
REQ-008 In LD_DATA the block SHALL pulse resp_valid, drive resp_rdata from mem_rdata, then go to IDLE; load latency is 2 cycles from the accept edge.
REQ-009 Load lane selection SHALL be:
- Byte lane = addr[1:0], halfword lane = addr[1].
- LB and LH sign-extend; LBU and LHU zero-extend.
REQ-010 In ST_WR the block SHALL drive mem_req=1, mem_we=1 and mem_wdata=req_wdata, pulse resp_valid, then go to IDLE.
REQ-011 In RMW_RD the block SHALL issue a read, then go to RMW_WR.
REQ-012 In RMW_WR the block SHALL write mem_rdata with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0], pulse resp_valid, then go to IDLE.
REQ-013 In ERR the block SHALL pulse resp_valid with resp_err=1 and resp_rdata=0, issue no mem_req, then go to IDLE.
REQ-014 Outside the states listed above, mem_req, mem_we and resp_valid SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-015 Addresses at or above 4*2^AW SHALL wrap: only bits [AW+1:0] of the address are used.
REQ-016 req_valid while req_ready is low SHALL be ignored; the pipeline holds the request, and the block takes no action.
REQ-017 req_ready SHALL be high in the same cycle that IDLE is re-entered after resp_valid, so back-to-back requests are possible.

Reset
REQ-018 On rst high at a clock edge the FSM SHALL go to IDLE.
REQ-019 During reset, outputs SHALL be:
- req_ready=1 in the first cycle after reset.
- resp_valid=0, resp_err=0, resp_rdata=0.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-020 Reset asserted during RMW_RD, LD_REQ or any other state SHALL abort the operation, with no memory write and no resp_valid.
REQ-021 Reset SHALL take priority over a simultaneous req_valid.

Structure
REQ-022 A shared package SHALL hold the following constants, shared with the decode stage:
- funct3 encodings.
- FSM state encodings.
- AW default.
REQ-023 Lane extraction and merge SHALL be one combinational sub-module, lsu_lane, with inputs word, addr[1:0], funct3 and wdata, and outputs load_data and merged_word.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- LW, addr 0x10, memory word 4 = 0x8899AABB -> mem_req with mem_addr=4 one cycle after accept; resp_valid one cycle later, resp_rdata=0x8899AABB.
- LB and LBU, addr 0x13, same word -> 0xFFFFFF88 and 0x00000088.
- LH and LHU, addr 0x12, same word -> 0xFFFF8899 and 0x00008899.
- SB, addr 0x21, wdata 0x000000CC, word 8 = 0x11223344 -> read then write 0x1122CC44; resp_valid on the write cycle.
- SH, addr 0x22, wdata 0xBEEF, word 8 = 0x11223344 -> memory word 8 becomes 0xBEEF3344.
- LW addr 0x02 -> resp_valid with resp_err=1 one cycle after accept, no mem_req.
- Store funct3 011 -> resp_valid with resp_err=1 one cycle after accept, no mem_req.
- rst asserted in RMW_RD of an SB -> no write, no resp_valid, req_ready=1 next cycle.
- LW at addr 0x100 -> mem_addr=0 (wrap).
